// File: rtl/mcu_snddma_pkg.sv
// rtl/mcu_snddma_pkg.sv - shared types and defaults for the sound DMA controller
package mcu_snddma_pkg;

    localparam int SND_NCH_DEF = 2;
    localparam int SND_AW_DEF  = 21;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_PLAY = 1'b1
    } ch_state_e;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mcu_snddma_if.sv
// rtl/mcu_snddma_if.sv - fetch strobe bus from the sound DMA controller to the memory side
interface mcu_snddma_if
    import mcu_snddma_pkg::*;
#(
    parameter int NCH = SND_NCH_DEF,
    parameter int AW  = SND_AW_DEF
) ();

    localparam int CW = ch_idx_w(NCH);

    logic          dma_load;
    logic [AW-1:0] dma_addr;
    logic [CW-1:0] dma_ch;

    modport master (output dma_load, dma_addr, dma_ch);
    modport slave  (input  dma_load, dma_addr, dma_ch);

endinterface

// File: rtl/mcu_snddma_chan.sv
// rtl/mcu_snddma_chan.sv - one sound DMA channel: play state, fetch address, frame end, request tracking
module mcu_snddma_chan
    import mcu_snddma_pkg::*;
#(
    parameter int AW = SND_AW_DEF
) (
    input  logic          clk,
    input  logic          resb,
    input  logic          en,
    input  logic          rep,
    input  logic          req,
    input  logic          svc,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic          active,
    output logic          pending,
    output logic          ovr,
    output logic          frame_end,
    output logic [AW-1:0] cur
);

    ch_state_e     state_q, state_d;
    logic [AW-1:0] cur_q, cur_d;
    logic [AW-1:0] end_q, end_d;
    logic          pend_q, pend_d;
    logic          ovr_q, ovr_d;
    logic [AW-1:0] cur_inc;

    assign cur_inc   = cur_q + AW'(1);
    assign frame_end = (cur_inc == end_q);
    assign active    = (state_q == CH_PLAY);
    assign pending   = pend_q;
    assign ovr       = ovr_q;
    assign cur       = cur_q;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        end_d   = end_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        if (state_q == CH_IDLE) begin
            if (en) begin
                state_d = CH_PLAY;
                cur_d   = start_addr;
                end_d   = end_addr;
                pend_d  = 1'b0;
            end
        end else if (!en) begin
            state_d = CH_IDLE;
            pend_d  = 1'b0;
            ovr_d   = 1'b0;
        end else if (svc) begin
            // a request arriving with its own service stays pending without overrun
            pend_d = req;
            cur_d  = cur_inc;
            if (frame_end) begin
                if (rep) begin
                    cur_d = start_addr;
                    end_d = end_addr;
                end else begin
                    state_d = CH_IDLE;
                    pend_d  = 1'b0;
                end
            end
        end else if (req) begin
            if (pend_q) ovr_d = 1'b1;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resb) begin
            state_q <= CH_IDLE;
            cur_q   <= '0;
            end_q   <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: rtl/mcu_snddma_ctrl.sv
// rtl/mcu_snddma_ctrl.sv - multi-channel sound DMA controller with round-robin slot arbitration
module mcu_snddma_ctrl
    import mcu_snddma_pkg::*;
#(
    parameter int NCH = SND_NCH_DEF,
    parameter int AW  = SND_AW_DEF
) (
    input  logic              clk,
    input  logic              resb,
    input  logic              cyc_slot,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH-1:0]    ch_rep,
    input  logic [NCH*AW-1:0] ch_start,
    input  logic [NCH*AW-1:0] ch_end,
    input  logic [NCH-1:0]    ch_req,
    output logic [NCH-1:0]    ch_active,
    output logic [NCH-1:0]    ch_int,
    output logic [NCH-1:0]    ch_ovr,
    output logic [NCH*AW-1:0] ch_cur,
    mcu_snddma_if.master      dma
);

    localparam int CW = ch_idx_w(NCH);

    logic [NCH-1:0] pend, fend, elig, svc;
    logic [AW-1:0]  cur_arr [NCH];
    logic [CW-1:0]  rr_q, rr_d, pick;
    logic           found;
    logic           load_q, load_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [CW-1:0]  chn_q, chn_d;
    logic [NCH-1:0] int_q, int_d;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        mcu_snddma_chan #(.AW(AW)) u_chan (
            .clk        (clk),
            .resb       (resb),
            .en         (ch_en[g]),
            .rep        (ch_rep[g]),
            .req        (ch_req[g]),
            .svc        (svc[g]),
            .start_addr (ch_start[g*AW +: AW]),
            .end_addr   (ch_end[g*AW +: AW]),
            .active     (ch_active[g]),
            .pending    (pend[g]),
            .ovr        (ch_ovr[g]),
            .frame_end  (fend[g]),
            .cur        (cur_arr[g])
        );
        assign ch_cur[g*AW +: AW] = cur_arr[g];
    end

    assign elig = ch_active & pend & ch_en;

    // lowest eligible index above the last served one, else lowest eligible overall
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (elig[c] && (CW'(c) > rr_q)) begin
                found = 1'b1;
                pick  = CW'(c);
            end
        end
        if (!found) begin
            for (int c = NCH - 1; c >= 0; c--) begin
                if (elig[c]) begin
                    found = 1'b1;
                    pick  = CW'(c);
                end
            end
        end
        for (int c = 0; c < NCH; c++) begin
            svc[c] = cyc_slot && found && (pick == CW'(c));
        end
    end

    always_comb begin
        load_d = 1'b0;
        addr_d = addr_q;
        chn_d  = chn_q;
        int_d  = '0;
        rr_d   = rr_q;
        if (cyc_slot && found) begin
            load_d = 1'b1;
            addr_d = cur_arr[pick];
            chn_d  = pick;
            int_d  = svc & fend;
            rr_d   = pick;
        end
    end

    always_ff @(posedge clk) begin
        if (!resb) begin
            load_q <= 1'b0;
            addr_q <= '0;
            chn_q  <= '0;
            int_q  <= '0;
            rr_q   <= CW'(NCH - 1);
        end else begin
            load_q <= load_d;
            addr_q <= addr_d;
            chn_q  <= chn_d;
            int_q  <= int_d;
            rr_q   <= rr_d;
        end
    end

    assign dma.dma_load = load_q;
    assign dma.dma_addr = addr_q;
    assign dma.dma_ch   = chn_q;
    assign ch_int       = int_q;

endmodule
